// File: rtl/spi_sub_shift.sv
// SPI subordinate serial engine: oversampled sclk/cs_n/mosi, MSB-first shifting,
// one-entry TX holding buffer. Optional frame counter under SPI_SUB_FRAME_CNT_EN.
module spi_sub_shift #(
   parameter int DATA_WIDTH  = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  pclk,
   input  logic                  presetn,
   input  logic                  se,
   input  logic                  cpol,
   input  logic                  cpha,
   input  logic                  sclk,
   input  logic                  cs_n,
   input  logic                  mosi,
   output logic                  miso,
   output logic                  miso_oe,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   output logic                  tx_underrun,
   output logic                  frame_abort,
   output logic [15:0]           frame_cnt
);

   localparam int CW = $clog2(DATA_WIDTH + 1);

   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t                  state;
   logic [SYNC_STAGES-1:0]  sclk_sync, cs_sync, mosi_sync;
   logic                    sclk_d, cs_d;
   logic                    sclk_s, cs_s, mosi_s;
   logic                    cpol_l, cpha_l;
   logic                    lead_edge, trail_edge, sample_edge, shift_edge;
   logic                    cs_fall, leave, start_frame, reload, load, frame_done;
   logic                    buf_full, skip_shift, reload_pending;
   logic [DATA_WIDTH-1:0]   buf_data, load_word, shift_reg, rx_next;
   logic [DATA_WIDTH-2:0]   rx_shift;
   logic [CW-1:0]           bit_cnt;

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         sclk_sync <= '0;
         cs_sync   <= '1;
         mosi_sync <= '0;
         sclk_d    <= 1'b0;
         cs_d      <= 1'b1;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
         sclk_d    <= sclk_sync[SYNC_STAGES-1];
         cs_d      <= cs_sync[SYNC_STAGES-1];
      end
   end

   assign sclk_s = sclk_sync[SYNC_STAGES-1];
   assign cs_s   = cs_sync[SYNC_STAGES-1];
   assign mosi_s = mosi_sync[SYNC_STAGES-1];

   // Edge roles are resolved against the mode latched at frame-sequence start.
   assign lead_edge   = (sclk_s != cpol_l) && (sclk_d == cpol_l);
   assign trail_edge  = (sclk_s == cpol_l) && (sclk_d != cpol_l);
   assign sample_edge = cpha_l ? trail_edge : lead_edge;
   assign shift_edge  = cpha_l ? lead_edge : trail_edge;

   assign cs_fall     = cs_d & ~cs_s;
   assign leave       = cs_s | ~se;
   assign start_frame = (state == IDLE) && cs_fall && se;
   assign reload      = (state == ACTIVE) && !leave && shift_edge && !skip_shift && reload_pending;
   assign load        = start_frame | reload;
   assign frame_done  = (state == ACTIVE) && !leave && sample_edge &&
                        (bit_cnt == CW'(DATA_WIDTH - 1));
   assign load_word   = buf_full ? buf_data : '0;
   assign rx_next     = {rx_shift, mosi_s};

   // TX handshake: a word transfers on any cycle where tx_valid && tx_ready; tx_ready is
   // simply "buffer empty", so a write in the same cycle as a load refills the buffer.
   assign tx_ready = ~buf_full;

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         buf_full <= 1'b0;
         buf_data <= '0;
      end else if (tx_valid && tx_ready) begin
         buf_full <= 1'b1;
         buf_data <= tx_data;
      end else if (load) begin
         buf_full <= 1'b0;
      end
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state          <= IDLE;
         miso_oe        <= 1'b0;
         shift_reg      <= '0;
         rx_shift       <= '0;
         rx_data        <= '0;
         rx_valid       <= 1'b0;
         tx_underrun    <= 1'b0;
         frame_abort    <= 1'b0;
         bit_cnt        <= '0;
         skip_shift     <= 1'b0;
         reload_pending <= 1'b0;
         cpol_l         <= 1'b0;
         cpha_l         <= 1'b0;
      end else begin
         rx_valid    <= 1'b0;
         tx_underrun <= 1'b0;
         frame_abort <= 1'b0;
         case (state)
            IDLE: begin
               if (start_frame) begin
                  state          <= ACTIVE;
                  miso_oe        <= 1'b1;
                  shift_reg      <= load_word;
                  tx_underrun    <= ~buf_full;
                  bit_cnt        <= '0;
                  skip_shift     <= cpha;
                  reload_pending <= 1'b0;
                  cpol_l         <= cpol;
                  cpha_l         <= cpha;
               end
            end
            ACTIVE: begin
               // Deselect has priority over any sclk edge seen in the same cycle.
               if (leave) begin
                  state       <= IDLE;
                  miso_oe     <= 1'b0;
                  bit_cnt     <= '0;
                  frame_abort <= (bit_cnt != '0);
               end else begin
                  if (sample_edge) begin
                     rx_shift <= rx_next[DATA_WIDTH-2:0];
                     if (frame_done) begin
                        rx_data        <= rx_next;
                        rx_valid       <= 1'b1;
                        bit_cnt        <= '0;
                        reload_pending <= 1'b1;
                     end else begin
                        bit_cnt <= bit_cnt + CW'(1);
                     end
                  end
                  if (shift_edge) begin
                     if (skip_shift) begin
                        skip_shift <= 1'b0;
                     end else if (reload_pending) begin
                        shift_reg      <= load_word;
                        tx_underrun    <= ~buf_full;
                        reload_pending <= 1'b0;
                     end else begin
                        shift_reg <= {shift_reg[DATA_WIDTH-2:0], 1'b0};
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign miso = miso_oe & shift_reg[DATA_WIDTH-1];

`ifdef SPI_SUB_FRAME_CNT_EN
   logic [15:0] frame_cnt_q;

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) frame_cnt_q <= 16'h0000;
      else if (frame_done) frame_cnt_q <= frame_cnt_q + 16'd1;
   end

   assign frame_cnt = frame_cnt_q;
`else
   assign frame_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_spi_sub_shift.sv
// Bench for spi_sub_shift: behavioural SPI master, word-level reference model,
// rx scoreboard queue and per-scenario checks.
`timescale 1ns/1ps
module tb_spi_sub_shift;
   localparam int W    = 8;
   localparam int HALF = 4;

   logic          pclk = 1'b0, presetn = 1'b0, se = 1'b0, cpol = 1'b0, cpha = 1'b0;
   logic          sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0, tx_valid = 1'b0;
   logic [W-1:0]  tx_data = '0;
   logic          miso, miso_oe, tx_ready, rx_valid, tx_underrun, frame_abort;
   logic [W-1:0]  rx_data;
   logic [15:0]   frame_cnt;

   int            n_tests = 0, n_fail = 0, model_frames = 0, und_cnt = 0, abort_cnt = 0;
   logic [W-1:0]  exp_q[$];
   logic [W-1:0]  rx_q[$];
   logic [W-1:0]  mosi_words[4], miso_words[4], tx_words[4];

   spi_sub_shift #(.DATA_WIDTH(W), .SYNC_STAGES(2)) dut (
      .pclk(pclk), .presetn(presetn), .se(se), .cpol(cpol), .cpha(cpha),
      .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso), .miso_oe(miso_oe),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .tx_underrun(tx_underrun),
      .frame_abort(frame_abort), .frame_cnt(frame_cnt)
   );

   always #5 pclk = ~pclk;

   always @(negedge pclk) begin
      if (presetn) begin
         if (rx_valid) rx_q.push_back(rx_data);
         if (tx_underrun) und_cnt++;
         if (frame_abort) abort_cnt++;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog simulation did not finish, required finish before 2ms");
      $fatal(1);
   end

   function automatic logic [15:0] exp_fc();
`ifdef SPI_SUB_FRAME_CNT_EN
      return 16'(model_frames);
`else
      return 16'h0000;
`endif
   endfunction

   task automatic wait_clks(input int n);
      repeat (n) @(negedge pclk);
   endtask

   task automatic wait_oe();
      int t = 0;
      while (miso_oe !== 1'b1 && t < 300) begin @(negedge pclk); t++; end
      n_tests++;
      if (miso_oe !== 1'b1) begin n_fail++; $display("FAIL oe_timeout miso_oe=%b required 1", miso_oe); end
   endtask

   task automatic write_tx(input logic [W-1:0] w);
      int t = 0;
      while (tx_ready !== 1'b1 && t < 400) begin @(negedge pclk); t++; end
      n_tests++;
      if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL tx_ready_timeout tx_ready=%b required 1", tx_ready); end
      tx_data  = w;
      tx_valid = 1'b1;
      @(negedge pclk);
      tx_valid = 1'b0;
   endtask

   // Master: mosi_words out, miso_words in; abort_after >= 0 deselects after that many sample edges.
   task automatic spi_xfer(input logic cp, input logic ch, input int nframes, input int abort_after);
      int edges = 0;
      bit stop  = 1'b0;
      cpol = cp; cpha = ch; sclk = cp;
      wait_clks(6);
      cs_n = 1'b0;
      wait_clks(HALF);
      for (int f = 0; f < nframes && !stop; f++) begin
         for (int b = W-1; b >= 0 && !stop; b--) begin
            if (abort_after >= 0 && edges == abort_after) begin
               stop = 1'b1;
            end else if (!ch) begin
               mosi = mosi_words[f][b];
               wait_clks(HALF);
               miso_words[f][b] = miso;
               sclk = ~cp; edges++;
               wait_clks(HALF);
               sclk = cp;
            end else begin
               wait_clks(HALF);
               sclk = ~cp;
               mosi = mosi_words[f][b];
               wait_clks(HALF);
               miso_words[f][b] = miso;
               sclk = cp; edges++;
            end
         end
      end
      if (!stop) wait_clks(HALF);
      cs_n = 1'b1;
      wait_clks(8);
   endtask

   task automatic test_reset();
      presetn = 1'b0; se = 1'b1;
      wait_clks(3);
      n_tests++; if (miso !== 1'b0) begin n_fail++; $display("FAIL reset_miso got=%b exp=0", miso); end
      n_tests++; if (miso_oe !== 1'b0) begin n_fail++; $display("FAIL reset_miso_oe got=%b exp=0", miso_oe); end
      n_tests++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_tx_ready got=%b exp=1", tx_ready); end
      n_tests++; if (rx_data !== '0) begin n_fail++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
      n_tests++; if ({rx_valid, tx_underrun, frame_abort} !== 3'b000) begin
         n_fail++; $display("FAIL reset_strobes got=%b exp=000", {rx_valid, tx_underrun, frame_abort}); end
      n_tests++; if (frame_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_frame_cnt got=%h exp=0000", frame_cnt); end
      presetn = 1'b1;
      model_frames = 0;
      wait_clks(5);
      n_tests++; if ({miso_oe, tx_ready} !== 2'b01) begin
         n_fail++; $display("FAIL reset_release_idle got=%b exp=01", {miso_oe, tx_ready}); end
   endtask

   task automatic test_mode0();
      int base = rx_q.size();
      int u0 = und_cnt;
      mosi_words[0] = 8'h3C;
      write_tx(8'hA5);
      n_tests++; if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL m0_tx_ready_full got=%b exp=0", tx_ready); end
      spi_xfer(1'b0, 1'b0, 1, -1);
      model_frames += 1;
      n_tests++; if (miso_words[0] !== 8'hA5) begin n_fail++; $display("FAIL m0_miso got=%h exp=a5", miso_words[0]); end
      n_tests++; if (rx_q.size() - base !== 1) begin n_fail++; $display("FAIL m0_rx_count got=%0d exp=1", rx_q.size() - base); end
      n_tests++; if (rx_data !== 8'h3C) begin n_fail++; $display("FAIL m0_rx_data got=%h exp=3c", rx_data); end
      n_tests++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL m0_tx_ready got=%b exp=1", tx_ready); end
      // mode 0 reloads on the trailing edge after the last bit; the buffer is empty there
      n_tests++; if (und_cnt - u0 !== 1) begin n_fail++; $display("FAIL m0_underrun got=%0d exp=1", und_cnt - u0); end
   endtask

   task automatic test_back_to_back();
      int base = rx_q.size();
      int u0 = und_cnt;
      logic [W-1:0] e;
      exp_q.delete();
      for (int k = 0; k < 2; k++) begin
         mosi_words[k] = 8'($urandom);
         exp_q.push_back(mosi_words[k]);
      end
      write_tx(8'h81);
      fork
         spi_xfer(1'b1, 1'b1, 2, -1);
         begin wait_oe(); write_tx(8'h7E); end
      join
      model_frames += 2;
      n_tests++; if (miso_words[0] !== 8'h81) begin n_fail++; $display("FAIL b2b_miso0 got=%h exp=81", miso_words[0]); end
      n_tests++; if (miso_words[1] !== 8'h7E) begin n_fail++; $display("FAIL b2b_miso1 got=%h exp=7e", miso_words[1]); end
      n_tests++; if (rx_q.size() - base !== 2) begin n_fail++; $display("FAIL b2b_rx_count got=%0d exp=2", rx_q.size() - base); end
      for (int k = 0; k < 2 && base + k < rx_q.size(); k++) begin
         e = exp_q[k];
         n_tests++; if (rx_q[base+k] !== e) begin n_fail++; $display("FAIL b2b_rx%0d got=%h exp=%h", k, rx_q[base+k], e); end
      end
      n_tests++; if (und_cnt - u0 !== 0) begin n_fail++; $display("FAIL b2b_underrun got=%0d exp=0", und_cnt - u0); end
      n_tests++; if (frame_cnt !== exp_fc()) begin n_fail++; $display("FAIL b2b_frame_cnt got=%h exp=%h", frame_cnt, exp_fc()); end
   endtask

   task automatic test_underrun();
      int base = rx_q.size();
      int u0 = und_cnt;
      n_tests++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL und_pre_empty got=%b exp=1", tx_ready); end
      mosi_words[0] = 8'($urandom);
      spi_xfer(1'b0, 1'b1, 1, -1);
      model_frames += 1;
      n_tests++; if (miso_words[0] !== 8'h00) begin n_fail++; $display("FAIL und_miso got=%h exp=00", miso_words[0]); end
      n_tests++; if (und_cnt - u0 !== 1) begin n_fail++; $display("FAIL und_pulse got=%0d exp=1", und_cnt - u0); end
      n_tests++; if (rx_q.size() - base !== 1) begin n_fail++; $display("FAIL und_rx_count got=%0d exp=1", rx_q.size() - base); end
      else if (rx_q[base] !== mosi_words[0]) begin
         n_fail++; $display("FAIL und_rx got=%h exp=%h", rx_q[base], mosi_words[0]); end
   endtask

   task automatic test_abort();
      int base = rx_q.size();
      int a0 = abort_cnt;
      logic [W-1:0] w1 = 8'($urandom);
      logic [W-1:0] w2 = 8'($urandom);
      mosi_words[0] = 8'($urandom);
      write_tx(w1);
      fork
         spi_xfer(1'b0, 1'b0, 1, 5);
         begin wait_oe(); write_tx(w2); end
      join
      n_tests++; if (abort_cnt - a0 !== 1) begin n_fail++; $display("FAIL abort_pulse got=%0d exp=1", abort_cnt - a0); end
      n_tests++; if (rx_q.size() - base !== 0) begin n_fail++; $display("FAIL abort_no_rx got=%0d exp=0", rx_q.size() - base); end
      n_tests++; if (miso_words[0][7:3] !== w1[7:3]) begin
         n_fail++; $display("FAIL abort_partial_miso got=%b exp=%b", miso_words[0][7:3], w1[7:3]); end
      n_tests++; if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL abort_buf_kept got=%b exp=0", tx_ready); end
      mosi_words[0] = 8'($urandom);
      base = rx_q.size();
      spi_xfer(1'b0, 1'b0, 1, -1);
      model_frames += 1;
      n_tests++; if (miso_words[0] !== w2) begin n_fail++; $display("FAIL abort_next_miso got=%h exp=%h", miso_words[0], w2); end
      n_tests++; if (rx_q.size() - base !== 1) begin n_fail++; $display("FAIL abort_next_count got=%0d exp=1", rx_q.size() - base); end
      else if (rx_q[base] !== mosi_words[0]) begin
         n_fail++; $display("FAIL abort_next_rx got=%h exp=%h", rx_q[base], mosi_words[0]); end
      n_tests++; if (frame_cnt !== exp_fc()) begin n_fail++; $display("FAIL abort_frame_cnt got=%h exp=%h", frame_cnt, exp_fc()); end
   endtask

   task automatic test_se_drop_reset();
      int base = rx_q.size();
      int a0 = abort_cnt;
      mosi_words[0] = 8'($urandom);
      write_tx(8'($urandom));
      fork
         spi_xfer(1'b0, 1'b0, 1, -1);
         begin wait_clks(40); se = 1'b0; end
      join
      se = 1'b1;
      wait_clks(4);
      n_tests++; if (abort_cnt - a0 !== 1) begin n_fail++; $display("FAIL se_drop_abort got=%0d exp=1", abort_cnt - a0); end
      n_tests++; if (rx_q.size() - base !== 0) begin n_fail++; $display("FAIL se_drop_no_rx got=%0d exp=0", rx_q.size() - base); end
      n_tests++; if (frame_cnt !== exp_fc()) begin n_fail++; $display("FAIL se_drop_frame_cnt got=%h exp=%h", frame_cnt, exp_fc()); end
      write_tx(8'($urandom));
      fork
         spi_xfer(1'b1, 1'b0, 1, -1);
         begin wait_oe(); write_tx(8'($urandom)); wait_clks(30); presetn = 1'b0; end
      join
      n_tests++; if ({miso, miso_oe, tx_ready, rx_valid, tx_underrun, frame_abort, frame_cnt} !== {6'b001000, 16'h0}) begin
         n_fail++; $display("FAIL midreset_outputs got=%b exp=%b",
            {miso, miso_oe, tx_ready, rx_valid, tx_underrun, frame_abort, frame_cnt}, {6'b001000, 16'h0}); end
      n_tests++; if (rx_data !== '0) begin n_fail++; $display("FAIL midreset_rx_data got=%h exp=00", rx_data); end
      presetn = 1'b1;
      model_frames = 0;
      wait_clks(6);
      n_tests++; if ({miso_oe, tx_ready, frame_cnt} !== {2'b01, 16'h0}) begin
         n_fail++; $display("FAIL midreset_release got=%b exp=%b", {miso_oe, tx_ready, frame_cnt}, {2'b01, 16'h0}); end
   endtask

   task automatic test_random();
      for (int it = 0; it < 6; it++) begin
         logic cp, ch, pre;
         int n, base, u0, eu;
         logic [W-1:0] em;
         cp  = 1'($urandom_range(0, 1));
         ch  = 1'($urandom_range(0, 1));
         pre = 1'($urandom_range(0, 1));
         n   = $urandom_range(1, 3);
         exp_q.delete();
         for (int k = 0; k < n; k++) begin
            mosi_words[k] = 8'($urandom);
            tx_words[k]   = 8'($urandom);
            exp_q.push_back(mosi_words[k]);
         end
         base = rx_q.size();
         u0   = und_cnt;
         if (pre) write_tx(tx_words[0]);
         fork
            spi_xfer(cp, ch, n, -1);
            begin
               if (n > 1) begin
                  wait_oe();
                  for (int k = 1; k < n; k++) write_tx(tx_words[k]);
               end
            end
         join
         model_frames += n;
         for (int k = 0; k < n; k++) begin
            em = (k == 0 && !pre) ? 8'h00 : tx_words[k];
            n_tests++; if (miso_words[k] !== em) begin
               n_fail++; $display("FAIL rnd%0d_miso%0d got=%h exp=%h", it, k, miso_words[k], em); end
         end
         n_tests++; if (rx_q.size() - base !== n) begin
            n_fail++; $display("FAIL rnd%0d_rx_count got=%0d exp=%0d", it, rx_q.size() - base, n); end
         for (int k = 0; k < n && base + k < rx_q.size(); k++) begin
            em = exp_q[k];
            n_tests++; if (rx_q[base+k] !== em) begin
               n_fail++; $display("FAIL rnd%0d_rx%0d got=%h exp=%h", it, k, rx_q[base+k], em); end
         end
         eu = (pre ? 0 : 1) + (ch ? 0 : 1);
         n_tests++; if (und_cnt - u0 !== eu) begin
            n_fail++; $display("FAIL rnd%0d_underrun got=%0d exp=%0d", it, und_cnt - u0, eu); end
         n_tests++; if (frame_cnt !== exp_fc()) begin
            n_fail++; $display("FAIL rnd%0d_frame_cnt got=%h exp=%h", it, frame_cnt, exp_fc()); end
         n_tests++; if (tx_ready !== 1'b1) begin
            n_fail++; $display("FAIL rnd%0d_tx_ready got=%b exp=1", it, tx_ready); end
      end
   endtask

   initial begin
      test_reset();
      test_mode0();
      test_back_to_back();
      test_underrun();
      test_abort();
      test_random();
      test_se_drop_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
